// File: rtl/servo_pkg.sv
// Shared types and default timing constants for the gripper servo PWM block.
package servo_pkg;

    localparam int CNT_W  = 20;
    localparam int NUM_CH = 8;

    typedef logic [CNT_W-1:0] cyc_t;

    localparam int unsigned PERIOD_CYC_DEF = 1_000_000;
    localparam int unsigned S_LO_CYC_DEF   = 50_000;
    localparam int unsigned S_HI_CYC_DEF   = 100_000;
    localparam int unsigned F_LO_CYC_DEF   = 50_000;
    localparam int unsigned F_HI_CYC_DEF   = 75_000;
    localparam int unsigned SLEW_STEP_DEF  = 500;

endpackage

// File: rtl/servo_pwm_channel.sv
// One servo PWM channel: latches its command at frame wrap and drives a
// registered pulse of the selected width from the shared frame counter.
module servo_pwm_channel
    import servo_pkg::*;
#(
    parameter int unsigned LO_CYC   = S_LO_CYC_DEF,
    parameter int unsigned HI_CYC   = S_HI_CYC_DEF,
    parameter int unsigned STEP_CYC = SLEW_STEP_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic cmd,
    input  cyc_t cnt,
    input  logic wrap,
    output logic pwm
);

    localparam cyc_t LO_W   = cyc_t'(LO_CYC);
    localparam cyc_t HI_W   = cyc_t'(HI_CYC);
    localparam cyc_t STEP_W = cyc_t'(STEP_CYC);

    cyc_t width;
    cyc_t target;
    cyc_t next_width;

    // Move toward the target by at most one step, landing exactly on it.
    // NOTE: defaults first so every path assigns next_width; otherwise a latch is inferred.
    always_comb begin
        target     = cmd ? HI_W : LO_W;
        next_width = target;
        if (width < target) begin
            if (target - width > STEP_W) next_width = width + STEP_W;
        end else if (width > target) begin
            if (width - target > STEP_W) next_width = width - STEP_W;
        end
    end

    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            width <= LO_W;
            pwm   <= 1'b0;
        end else begin
            if (wrap) width <= next_width;
            pwm <= (cnt < width);
        end
    end

endmodule

// File: rtl/servo_control.sv
// Eight-channel hobby-servo PWM generator sharing one 20 ms frame counter.
// Optional macro SERVO_SLEW_EN limits width change to SLEW_STEP per frame.
module servo_control
    import servo_pkg::*;
#(
    parameter int unsigned PERIOD_CYC = PERIOD_CYC_DEF,
    parameter int unsigned S_LO_CYC   = S_LO_CYC_DEF,
    parameter int unsigned S_HI_CYC   = S_HI_CYC_DEF,
    parameter int unsigned F_LO_CYC   = F_LO_CYC_DEF,
    parameter int unsigned F_HI_CYC   = F_HI_CYC_DEF,
    parameter int unsigned SLEW_STEP  = SLEW_STEP_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic s1,
    input  logic s2,
    input  logic s3,
    input  logic s4,
    input  logic f1,
    input  logic f2,
    input  logic f3,
    input  logic f4,
    output logic servo1,
    output logic servo2,
    output logic servo3,
    output logic servo4,
    output logic servo_t,
    output logic servo_l,
    output logic servo_b,
    output logic servo_r
);

    localparam cyc_t LAST = cyc_t'(PERIOD_CYC - 1);

`ifdef SERVO_SLEW_EN
    localparam int unsigned STEP_CYC = SLEW_STEP;
`else
    // A step as large as the frame always reaches the target in one update.
    localparam int unsigned STEP_CYC = PERIOD_CYC;
`endif

    if (PERIOD_CYC < 2 || PERIOD_CYC > (32'd1 << CNT_W) ||
        S_LO_CYC == 0 || S_LO_CYC >= PERIOD_CYC ||
        S_HI_CYC == 0 || S_HI_CYC >= PERIOD_CYC ||
        F_LO_CYC == 0 || F_LO_CYC >= PERIOD_CYC ||
        F_HI_CYC == 0 || F_HI_CYC >= PERIOD_CYC ||
        SLEW_STEP == 0) begin : g_bad_params
        $error("servo_control: pulse widths must be nonzero and below PERIOD_CYC");
    end

    cyc_t              cnt;
    logic              wrap;
    logic [NUM_CH-1:0] cmd;
    logic [NUM_CH-1:0] pwm;

    assign wrap = (cnt == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      cnt <= '0;
        else if (wrap) cnt <= '0;
        else           cnt <= cnt + cyc_t'(1);
    end

    assign cmd = {f4, f3, f2, f1, s4, s3, s2, s1};

    // Channels 0-3 are the linear servos, 4-7 the rotary ones.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        servo_pwm_channel #(
            .LO_CYC  (i < 4 ? S_LO_CYC : F_LO_CYC),
            .HI_CYC  (i < 4 ? S_HI_CYC : F_HI_CYC),
            .STEP_CYC(STEP_CYC)
        ) u_ch (
            .clk (clk),
            .rst (rst),
            .cmd (cmd[i]),
            .cnt (cnt),
            .wrap(wrap),
            .pwm (pwm[i])
        );
    end

    assign {servo_r, servo_b, servo_l, servo_t, servo4, servo3, servo2, servo1} = pwm;

endmodule

// File: tb/tb_servo_control.sv
// Directed bench for servo_control with a 100-cycle frame; frame-by-frame
// pulse-width measurement of all eight outputs.
module tb_servo_control;

    localparam int PER = 100;

    typedef int w8_t [8];

    logic       clk;
    logic       rst;
    logic [7:0] cmd;
    logic       servo1, servo2, servo3, servo4;
    logic       servo_t, servo_l, servo_b, servo_r;
    logic [7:0] pwm;

    int n_cmp = 0;
    int n_bad = 0;

    string ch_name [8] = '{"servo1", "servo2", "servo3", "servo4",
                           "servo_t", "servo_l", "servo_b", "servo_r"};

    servo_control #(
        .PERIOD_CYC(PER),
        .S_LO_CYC  (10),
        .S_HI_CYC  (20),
        .F_LO_CYC  (10),
        .F_HI_CYC  (15),
        .SLEW_STEP (2)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .s1     (cmd[0]),
        .s2     (cmd[1]),
        .s3     (cmd[2]),
        .s4     (cmd[3]),
        .f1     (cmd[4]),
        .f2     (cmd[5]),
        .f3     (cmd[6]),
        .f4     (cmd[7]),
        .servo1 (servo1),
        .servo2 (servo2),
        .servo3 (servo3),
        .servo4 (servo4),
        .servo_t(servo_t),
        .servo_l(servo_l),
        .servo_b(servo_b),
        .servo_r(servo_r)
    );

    assign pwm = {servo_r, servo_b, servo_l, servo_t, servo4, servo3, servo2, servo1};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Expected widths for a set of latched commands (no slew).
    function automatic w8_t widths_of(input logic [7:0] l);
        w8_t r;
        for (int ch = 0; ch < 8; ch++)
            r[ch] = (ch < 4) ? (l[ch] ? 20 : 10) : (l[ch] ? 15 : 10);
        return r;
    endfunction

    function automatic w8_t with_servo2(input int v);
        w8_t r;
        r = widths_of(8'h00);
        r[1] = v;
        return r;
    endfunction

    // Runs one aligned frame; the pulse of each output must start at the
    // frame's first sample and be one contiguous run. Up to two command
    // changes are applied right after the given sample index.
    task automatic run_frame(input string tag, input w8_t expw,
                             input int ev1_at, input logic [7:0] ev1_cmd,
                             input int ev2_at, input logic [7:0] ev2_cmd);
        int lead [8];
        int total [8];
        bit gone [8];
        for (int ch = 0; ch < 8; ch++) begin
            lead[ch] = 0; total[ch] = 0; gone[ch] = 1'b0;
        end
        for (int i = 0; i < PER; i++) begin
            @(posedge clk);
            @(negedge clk);
            for (int ch = 0; ch < 8; ch++) begin
                if (pwm[ch]) begin
                    total[ch]++;
                    if (!gone[ch]) lead[ch]++;
                end else begin
                    gone[ch] = 1'b1;
                end
            end
            if (i == ev1_at) cmd = ev1_cmd;
            if (i == ev2_at) cmd = ev2_cmd;
        end
        for (int ch = 0; ch < 8; ch++)
            check($sformatf("%s_%s", tag, ch_name[ch]),
                  (total[ch] == lead[ch]) ? lead[ch] : -1, expw[ch]);
    endtask

    initial begin
        rst = 1'b0;
        cmd = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_outputs", int'(pwm), 0);
        rst = 1'b1;

`ifdef SERVO_SLEW_EN
        run_frame("slew_f0", widths_of(8'h00), 40, 8'h02, -1, 8'h00);
        run_frame("slew_f1", with_servo2(12), -1, 8'h00, -1, 8'h00);
        run_frame("slew_f2", with_servo2(14), -1, 8'h00, -1, 8'h00);
        run_frame("slew_f3", with_servo2(16), -1, 8'h00, -1, 8'h00);
        run_frame("slew_f4", with_servo2(18), -1, 8'h00, -1, 8'h00);
        run_frame("slew_f5", with_servo2(20), -1, 8'h00, -1, 8'h00);
        run_frame("slew_f6", with_servo2(20), 40, 8'h00, -1, 8'h00);
        run_frame("slew_down", with_servo2(18), -1, 8'h00, -1, 8'h00);
`else
        run_frame("idle_f0", widths_of(8'h00), -1, 8'h00, -1, 8'h00);
        run_frame("s1_mid", widths_of(8'h00), 40, 8'h01, -1, 8'h00);
        run_frame("s1_next", widths_of(8'h01), 40, 8'hA1, -1, 8'h00);
        run_frame("f2f4_next", widths_of(8'hA1), 30, 8'hA5, 60, 8'hA1);
        run_frame("s3_glitch", widths_of(8'hA1), 98, 8'h02, -1, 8'h00);
        run_frame("late_cmd", widths_of(8'h02), 99, 8'h00, -1, 8'h00);
        run_frame("after_wrap", widths_of(8'h02), -1, 8'h00, -1, 8'h00);
        run_frame("cleared", widths_of(8'h00), -1, 8'h00, -1, 8'h00);

        // Reset while every pulse is high, five cycles into a frame.
        cmd = 8'h01;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("pre_reset_high", int'(pwm), 255);
        #1 rst = 1'b0;
        #1 check("async_drop", int'(pwm), 0);
        repeat (2) @(negedge clk);
        check("reset_hold", int'(pwm), 0);
        rst = 1'b1;
        run_frame("post_reset", widths_of(8'h00), -1, 8'h00, -1, 8'h00);
        run_frame("post_reset_s1", widths_of(8'h01), -1, 8'h00, -1, 8'h00);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
